// File: rtl/bcd_scan_ctrl_if.sv
// rtl/bcd_scan_ctrl_if.sv - display scanner bus bundle
//
// Groups the scan-enable / BCD input word and the display-side outputs of
// bcd_scan_ctrl. The master side drives enable, digits_in and dp_in; the
// slave side (the scanner) drives digit, dp, anode, blank, frame_start and
// index.
//   enable      : scan enable
//   digits_in   : packed BCD digits, [3:0] is the ones digit
//   dp_in       : decimal point per digit
//   digit, dp   : nibble and decimal point of the lit digit
//   anode       : one-hot active-low digit enables
//   blank       : no digit lit this cycle
//   frame_start : one-cycle pulse after each snapshot load
//   index       : current slot number
interface bcd_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    enable;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [3:0]              digit;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    blank;
    logic                    frame_start;
    logic [IW-1:0]           index;

    modport master (
        output enable, digits_in, dp_in,
        input  digit, dp, anode, blank, frame_start, index
    );

    modport slave (
        input  enable, digits_in, dp_in,
        output digit, dp, anode, blank, frame_start, index
    );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// rtl/bcd_scan_ctrl.sv - multiplexed 7-segment digit scanner with frame snapshot
//
// Owns a refresh prescaler and a slot counter, lights one digit per slot
// (active-low one-hot anodes) and snapshots the BCD word once per frame so
// the display never tears. Outputs decode from registered state only.
// Optional feature macro: BCD_SCAN_LZB_EN (leading-zero blanking).
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : bcd_scan_ctrl_if slave modport (inputs enable, digits_in, dp_in;
//           outputs digit, dp, anode, blank, frame_start, index)
module bcd_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic           clk,
    input  logic           reset,
    bcd_scan_ctrl_if.slave bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           index_q;
    logic [4*NUM_DIGITS-1:0] snap_d;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic                    en_q;
    logic                    load_pending;
    logic                    frame_start_q;

    logic tc;
    logic load;

    always_comb begin
        tc   = bus.enable && (presc == PRESC_LAST);
        // Load at the frame wrap, or on the first enabled cycle after reset
        // or a disable, so a resumed display never shows a stale word.
        load = bus.enable && (load_pending || (tc && (index_q == INDEX_LAST)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc         <= '0;
            index_q       <= '0;
            snap_d        <= '0;
            snap_dp       <= '0;
            en_q          <= 1'b0;
            load_pending  <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            en_q          <= bus.enable;
            frame_start_q <= load;

            if (tc) begin
                presc   <= '0;
                index_q <= (index_q == INDEX_LAST) ? '0 : index_q + IW'(1);
            end else if (bus.enable) begin
                presc <= presc + PW'(1);
            end

            if (load) begin
                snap_d  <= bus.digits_in;
                snap_dp <= bus.dp_in;
            end

            if (!bus.enable) begin
                load_pending <= 1'b1;
            end else if (load) begin
                load_pending <= 1'b0;
            end
        end
    end

    // blk[i] marks slot i as a leading zero to be kept dark.
    logic [NUM_DIGITS-1:0] blk;

`ifdef BCD_SCAN_LZB_EN
    logic zero_run;

    // Walk down from the most significant digit; a slot stays blank only
    // while every nibble and decimal point at or above it is zero.
    always_comb begin
        zero_run = 1'b1;
        blk      = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (snap_d[4*i +: 4] == 4'd0) && !snap_dp[i];
            blk[i]   = zero_run;
        end
    end
`else
    assign blk = '0;
`endif

    logic [NUM_DIGITS-1:0] anode_c;
    logic [3:0]            digit_c;
    logic                  dp_c;
    logic                  blank_c;

    always_comb begin
        anode_c = '1;
        digit_c = 4'd0;
        dp_c    = 1'b0;
        blank_c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (en_q && (index_q == IW'(i)) && !blk[i]) begin
                anode_c[i] = 1'b0;
                digit_c    = snap_d[4*i +: 4];
                dp_c       = snap_dp[i];
                blank_c    = 1'b0;
            end
        end
    end

    assign bus.anode       = anode_c;
    assign bus.digit       = digit_c;
    assign bus.dp          = dp_c;
    assign bus.blank       = blank_c;
    assign bus.frame_start = frame_start_q;
    assign bus.index       = index_q;
endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb/tb_bcd_scan_ctrl.sv - scoreboard bench for bcd_scan_ctrl (4x4 and 6x2 builds)
module tb_bcd_scan_ctrl;
    logic clk;
    logic reset;

    bcd_scan_ctrl_if #(.NUM_DIGITS(4)) ba ();
    bcd_scan_ctrl_if #(.NUM_DIGITS(6)) bb ();

    bcd_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ba)
    );

    bcd_scan_ctrl #(.NUM_DIGITS(6), .REFRESH_DIV(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] snap;
        logic [7:0]  sdp;
        int          ecnt;
        logic        en_prev;
        logic        pending;
        logic        fs;
    } mstate_t;

    typedef struct packed {
        logic [7:0] anode;
        logic [3:0] digit;
        logic       dp;
        logic       blank;
        logic       fs;
        logic [2:0] index;
    } mout_t;

    mstate_t sa, sb;
    mout_t   qa[$];
    mout_t   qb[$];
    int      n_checks = 0;
    int      n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else             n_pass++;
    endtask

    // Behavioural reference: slot position follows from the count of enabled
    // cycles since reset; a frame wraps every nd*rd enabled cycles.
    function automatic mstate_t m_step(mstate_t s, int nd, int rd, logic rst, logic en,
                                       logic [31:0] din, logic [7:0] dpin);
        mstate_t     n;
        logic        wrap;
        logic        ld;
        logic [63:0] dmask;
        n = s;
        if (rst) begin
            n.snap = '0; n.sdp = '0; n.ecnt = 0;
            n.en_prev = 1'b0; n.pending = 1'b1; n.fs = 1'b0;
        end else begin
            wrap  = en && (((s.ecnt + 1) % (nd * rd)) == 0);
            ld    = en && (s.pending || wrap);
            dmask = (64'd1 << (4 * nd)) - 64'd1;
            n.fs  = ld;
            if (ld) begin
                n.snap = din & dmask[31:0];
                n.sdp  = dpin & 8'((16'd1 << nd) - 16'd1);
            end
            n.pending = !en || (s.pending && !ld);
            if (en) n.ecnt = s.ecnt + 1;
            n.en_prev = en;
        end
        return n;
    endfunction

    function automatic int m_slot(mstate_t s, int nd, int rd);
        return (s.ecnt / rd) % nd;
    endfunction

    function automatic mout_t m_expect(mstate_t s, int nd, int rd);
        mout_t      o;
        int         slot;
        logic [7:0] ones;
        logic       lit;
        ones    = 8'((16'd1 << nd) - 16'd1);
        slot    = m_slot(s, nd, rd);
        o.index = 3'(slot);
        o.fs    = s.fs;
        o.anode = ones;
        o.digit = 4'd0;
        o.dp    = 1'b0;
        o.blank = 1'b1;
        lit     = s.en_prev;
`ifdef BCD_SCAN_LZB_EN
        if (slot > 0 && (s.snap >> (4 * slot)) == 32'd0 && (s.sdp >> slot) == 8'd0) lit = 1'b0;
`endif
        if (lit) begin
            o.anode = ones & ~8'(1 << slot);
            o.digit = 4'(s.snap >> (4 * slot));
            o.dp    = s.sdp[slot];
            o.blank = 1'b0;
        end
        return o;
    endfunction

    task automatic tick();
        mout_t ea, eb;
        @(posedge clk);
        sa = m_step(sa, 4, 4, reset, ba.enable, 32'(ba.digits_in), 8'(ba.dp_in));
        sb = m_step(sb, 6, 2, reset, bb.enable, 32'(bb.digits_in), 8'(bb.dp_in));
        qa.push_back(m_expect(sa, 4, 4));
        qb.push_back(m_expect(sb, 6, 2));
        @(negedge clk);
        ea = qa.pop_front();
        eb = qb.pop_front();
        check("a_anode", 32'(ba.anode),       32'(ea.anode));
        check("a_digit", 32'(ba.digit),       32'(ea.digit));
        check("a_dp",    32'(ba.dp),          32'(ea.dp));
        check("a_blank", 32'(ba.blank),       32'(ea.blank));
        check("a_fs",    32'(ba.frame_start), 32'(ea.fs));
        check("a_index", 32'(ba.index),       32'(ea.index));
        check("b_anode", 32'(bb.anode),       32'(eb.anode));
        check("b_digit", 32'(bb.digit),       32'(eb.digit));
        check("b_dp",    32'(bb.dp),          32'(eb.dp));
        check("b_blank", 32'(bb.blank),       32'(eb.blank));
        check("b_fs",    32'(bb.frame_start), 32'(eb.fs));
        check("b_index", 32'(bb.index),       32'(eb.index));
    endtask

    initial begin
        sa = '0;
        sb = '0;
        reset        = 1'b1;
        ba.enable    = 1'b0;
        ba.digits_in = '0;
        ba.dp_in     = '0;
        bb.enable    = 1'b0;
        bb.digits_in = '0;
        bb.dp_in     = '0;
        repeat (2) tick();
        check("rst_anode", 32'(ba.anode), 32'h0000_000f);
        check("rst_blank", 32'(ba.blank), 32'd1);
        check("rst_index", 32'(ba.index), 32'd0);
        check("rst_fs",    32'(ba.frame_start), 32'd0);

        // Scan 1234 on the 4-digit build, a fixed word on the 6-digit build.
        reset        = 1'b0;
        ba.enable    = 1'b1;
        ba.digits_in = 16'h1234;
        bb.enable    = 1'b1;
        bb.digits_in = 24'h987654;
        bb.dp_in     = 6'b000101;
        tick();
        check("s1_fs",    32'(ba.frame_start), 32'd1);
        check("s1_digit", 32'(ba.digit), 32'd4);
        check("s1_anode", 32'(ba.anode), 32'h0000_000e);
        tick();
        check("s1_fs_end", 32'(ba.frame_start), 32'd0);
        repeat (20) tick();

        // Input change mid-frame only shows after the wrap.
        for (int k = 0; k < 32 && m_slot(sa, 4, 4) != 1; k++) tick();
        check("s2_sync", 32'(ba.index), 32'd1);
        ba.digits_in = 16'h5678;
        tick();
        check("s2_hold", 32'(ba.digit), 32'd3);
        repeat (20) tick();

        // Disable at presc=1 of slot 2, then resume.
        for (int k = 0; k < 40 && !(m_slot(sa, 4, 4) == 2 && (sa.ecnt % 4) == 1); k++) tick();
        check("s4_sync", 32'(ba.index), 32'd2);
        ba.enable = 1'b0;
        tick();
        check("s4_dark",  32'(ba.anode), 32'h0000_000f);
        check("s4_blank", 32'(ba.blank), 32'd1);
        repeat (9) tick();
        ba.enable = 1'b1;
        repeat (12) tick();

        // Reset during slot 3.
        for (int k = 0; k < 40 && m_slot(sa, 4, 4) != 3; k++) tick();
        check("s5_sync", 32'(ba.index), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("s5_anode", 32'(ba.anode), 32'h0000_000f);
        check("s5_index", 32'(ba.index), 32'd0);
        check("s5_fs",    32'(ba.frame_start), 32'd0);
        repeat (12) tick();

        // Leading zeros, decimal point on a zero digit, nibbles above 9.
        ba.digits_in = 16'h0070;
        ba.dp_in     = 4'b0000;
        repeat (20) tick();
        ba.dp_in     = 4'b1000;
        repeat (20) tick();
        ba.digits_in = 16'hfa0c;
        ba.dp_in     = 4'b0101;
        bb.digits_in = 24'h00000f;
        bb.dp_in     = 6'b000000;
        repeat (20) tick();

        // Random enables and input words on both builds.
        repeat (80) begin
            ba.enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) ba.digits_in = 16'($urandom);
            ba.dp_in = 4'($urandom);
            bb.enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) bb.digits_in = 24'($urandom);
            bb.dp_in = 6'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
